// File: rtl/zap_wb_ram_slave.sv
// Wishbone B3 slave RAM with classic/incrementing-burst support and optional wait/stall insertion.
// Latency shaping stresses the master's fill and store paths; the array is not cleared on reset.
module zap_wb_ram_slave #(
  parameter int          SIZE_IN_BYTES = 32768,
  parameter int          WAIT_CYCLES   = 0,
  parameter bit          STALL_EN      = 1'b0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter string       INIT_FILE     = ""
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [3:0]  i_wb_sel,
  input  logic [2:0]  i_wb_cti,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic [1:0]  o_dbg_state
);

  localparam int         WORDS     = SIZE_IN_BYTES / 4;
  localparam int         AW        = $clog2(WORDS);
  localparam logic [2:0] CTI_INCR  = 3'b010;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

  state_t        state, state_nxt;
  logic [31:0]   ram [0:WORDS-1];
  logic [AW-1:0] ptr, ptr_nxt, rd_idx;
  logic [3:0]    cnt, cnt_nxt;
  logic          ack_nxt, load, commit, beat_done;
  logic [15:0]   lfsr;
  logic          unused_adr;

  assign unused_adr  = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};
  assign o_dbg_state = state;
  assign beat_done   = o_wb_ack & i_wb_cyc & i_wb_stb;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    ack_nxt   = o_wb_ack;
    rd_idx    = ptr;
    load      = 1'b0;
    commit    = 1'b0;
    if (!i_wb_cyc) begin
      // Abort: any beat not yet completed is simply dropped.
      state_nxt = S_IDLE;
      ack_nxt   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_wb_stb) begin
            ptr_nxt = i_wb_adr[AW+1:2];
            cnt_nxt = WAIT_LOAD;
            rd_idx  = i_wb_adr[AW+1:2];
            if (WAIT_LOAD == 4'd0) begin
              state_nxt = S_ACK;
              ack_nxt   = 1'b1;
              load      = 1'b1;
            end else begin
              state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nxt = S_ACK;
            ack_nxt   = 1'b1;
            load      = 1'b1;
          end
        end
        S_ACK, S_BURST: begin
          if (beat_done) begin
            commit = i_wb_we;
            if (i_wb_cti == CTI_INCR) begin
              // Pointer advances before the load, so the write and the read never share a word.
              ptr_nxt   = ptr + 1'b1;
              rd_idx    = ptr + 1'b1;
              load      = 1'b1;
              state_nxt = S_BURST;
              ack_nxt   = !(STALL_EN && lfsr[0]);
            end else begin
              state_nxt = S_IDLE;
              ack_nxt   = 1'b0;
            end
          end else begin
            // Strobe gaps and stall gaps both resolve by following stb.
            ack_nxt = i_wb_stb;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack <= 1'b0;
      o_wb_dat <= 32'h0;
      ptr      <= '0;
      cnt      <= 4'd0;
      lfsr     <= LFSR_SEED;
    end else begin
      o_wb_ack <= ack_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (load) o_wb_dat <= ram[rd_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) ram[ptr][8*b +: 8] <= i_wb_dat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_zap_wb_ram_slave.sv
// Directed bench for zap_wb_ram_slave: three instances cover zero wait, three wait states and LFSR stalls.
module tb_zap_wb_ram_slave;

  logic        clk;
  logic        rst_n;
  logic        cyc [3];
  logic        stb [3];
  logic        we  [3];
  logic [31:0] adr [3];
  logic [31:0] wdat[3];
  logic [31:0] rdat[3];
  logic [3:0]  sel [3];
  logic [2:0]  cti [3];
  logic        ack [3];
  logic [1:0]  dbg [3];
  logic [15:0] ref_lfsr;

  logic [31:0] bw[8];
  logic [31:0] br[8];
  int          bat[8];
  bit          bgap[8];
  int          total = 0;
  int          bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  zap_wb_ram_slave #(.WAIT_CYCLES(0)) u_w0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
    .i_wb_adr(adr[0]), .i_wb_sel(sel[0]), .i_wb_cti(cti[0]), .i_wb_dat(wdat[0]),
    .o_wb_dat(rdat[0]), .o_wb_ack(ack[0]), .o_dbg_state(dbg[0]));

  zap_wb_ram_slave #(.WAIT_CYCLES(3)) u_w3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
    .i_wb_adr(adr[1]), .i_wb_sel(sel[1]), .i_wb_cti(cti[1]), .i_wb_dat(wdat[1]),
    .o_wb_dat(rdat[1]), .o_wb_ack(ack[1]), .o_dbg_state(dbg[1]));

  zap_wb_ram_slave #(.WAIT_CYCLES(0), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) u_st (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .i_wb_we(we[2]),
    .i_wb_adr(adr[2]), .i_wb_sel(sel[2]), .i_wb_cti(cti[2]), .i_wb_dat(wdat[2]),
    .o_wb_dat(rdat[2]), .o_wb_ack(ack[2]), .o_dbg_state(dbg[2]));

  // Reference Fibonacci LFSR, taps 16/14/13/11, newest bit enters at bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_lfsr <= 16'hACE1;
    else        ref_lfsr <= lfsr_step(ref_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int i, input int a, input logic [31:0] v);
    case (i)
      0:       u_w0.ram[a] = v;
      1:       u_w3.ram[a] = v;
      default: u_st.ram[a] = v;
    endcase
  endtask

  function automatic logic [31:0] peek(input int i, input int a);
    case (i)
      0:       return u_w0.ram[a];
      1:       return u_w3.ram[a];
      default: return u_st.ram[a];
    endcase
  endfunction

  task automatic drive_beat(input int i, input int k, input int n);
    if (n == 1)          cti[i] = 3'b000;
    else if (k == n - 1) cti[i] = 3'b111;
    else                 cti[i] = 3'b010;
    wdat[i] = bw[k];
  endtask

  // Runs an n-beat transfer (n=1 is classic); records ack cycle, read data and LFSR bit per beat.
  task automatic burst(input int i, input bit w, input logic [31:0] a, input int n, input logic [3:0] s);
    int k;
    int cyc_n;
    bit hit;
    k = 0;
    cyc_n = 0;
    for (int j = 0; j < 8; j++) begin
      br[j] = 32'h0; bat[j] = -1; bgap[j] = 1'b0;
    end
    adr[i] = a; we[i] = w; sel[i] = s; stb[i] = 1'b1; cyc[i] = 1'b1;
    drive_beat(i, 0, n);
    while (k < n && cyc_n < 100) begin
      hit = ack[i];
      if (hit) begin
        br[k] = rdat[i]; bat[k] = cyc_n; bgap[k] = ref_lfsr[0];
      end
      @(posedge clk); #1;
      cyc_n++;
      if (hit) begin
        k++;
        if (k < n) drive_beat(i, k, n);
      end
    end
    cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; cti[i] = 3'b000;
    check("beats_done", k, n);
  endtask

  initial begin
    logic [31:0] tmp;
    int acc;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = 0; wdat[i] = 0; sel[i] = 0; cti[i] = 0;
    end
    for (int j = 0; j < 8; j++) bw[j] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_ack", {31'h0, ack[i]}, 32'h0);
      check("reset_dat", rdat[i], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Classic read, zero wait states
    poke(0, 3, 32'hDEADBEEF);
    burst(0, 1'b0, 32'h0000_000C, 1, 4'hF);
    check("classic_lat", bat[0], 1);
    check("classic_dat", br[0], 32'hDEADBEEF);
    check("classic_ack_drop", {31'h0, ack[0]}, 32'h0);

    // Byte-lane write then readback
    poke(0, 1, 32'h11223344);
    bw[0] = 32'hAABBCCDD;
    burst(0, 1'b1, 32'h0000_0004, 1, 4'b0110);
    check("bytewr_ram", peek(0, 1), 32'h11BBCC44);
    burst(0, 1'b0, 32'h0000_0004, 1, 4'hF);
    check("bytewr_read", br[0], 32'h11BBCC44);

    // 4-beat read burst wrapping past the top of the array
    poke(0, 8190, 32'hA0A0_0000);
    poke(0, 8191, 32'hA1A1_0001);
    poke(0, 0,    32'hA2A2_0002);
    poke(0, 1,    32'hA3A3_0003);
    burst(0, 1'b0, 32'h0000_7FF8, 4, 4'hF);
    check("wrap_d0", br[0], 32'hA0A0_0000);
    check("wrap_d1", br[1], 32'hA1A1_0001);
    check("wrap_d2", br[2], 32'hA2A2_0002);
    check("wrap_d3", br[3], 32'hA3A3_0003);
    for (int k = 0; k < 4; k++) check("wrap_ack_cycle", bat[k], k + 1);
    check("wrap_ack_drop", {31'h0, ack[0]}, 32'h0);

    // Three wait states, 4-beat write burst
    for (int k = 0; k < 4; k++) bw[k] = 32'hC0DE_0000 + k;
    burst(1, 1'b1, 32'h0000_0100, 4, 4'hF);
    for (int k = 0; k < 4; k++) check("w3_ack_cycle", bat[k], k + 4);
    for (int k = 0; k < 4; k++) check("w3_ram", peek(1, 64 + k), 32'hC0DE_0000 + k);
    burst(1, 1'b0, 32'h0000_0104, 1, 4'hF);
    check("w3_read_lat", bat[0], 4);
    check("w3_read_dat", br[0], 32'hC0DE_0001);

    // Abort during wait states: no ack, no write, back to idle
    poke(1, 80, 32'h55AA_55AA);
    adr[1] = 32'h0000_0140; we[1] = 1'b1; sel[1] = 4'hF; cti[1] = 3'b000;
    wdat[1] = 32'h1234_5678; cyc[1] = 1'b1; stb[1] = 1'b1;
    acc = 0;
    repeat (2) begin
      @(posedge clk); #1;
      acc += int'(ack[1]);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(posedge clk); #1;
    check("abort_state", {30'h0, dbg[1]}, 32'h0);
    repeat (4) begin
      acc += int'(ack[1]);
      @(posedge clk); #1;
    end
    check("abort_no_ack", acc, 0);
    check("abort_no_write", peek(1, 80), 32'h55AA_55AA);
    burst(1, 1'b0, 32'h0000_0140, 1, 4'hF);
    check("abort_then_read_lat", bat[0], 4);
    check("abort_then_read_dat", br[0], 32'h55AA_55AA);

    // LFSR stall gaps inside an 8-beat write burst
    for (int k = 0; k < 8; k++) bw[k] = 32'h5700_0000 + k * 32'h0101;
    burst(2, 1'b1, 32'h0000_0200, 8, 4'hF);
    check("stall_first_ack", bat[0], 1);
    for (int k = 0; k < 7; k++) check("stall_gap", bat[k + 1] - bat[k], 1 + int'(bgap[k]));
    for (int k = 0; k < 8; k++) check("stall_ram", peek(2, 128 + k), 32'h5700_0000 + k * 32'h0101);

    // Reset asserted during beat 2 of a write burst
    for (int k = 192; k < 195; k++) poke(0, k, 32'h0);
    adr[0] = 32'h0000_0300; we[0] = 1'b1; sel[0] = 4'hF; cti[0] = 3'b010;
    wdat[0] = 32'hB0B0_B0B0; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk); #1;
    check("mrst_b0_ack", {31'h0, ack[0]}, 32'h1);
    @(posedge clk); #1;
    wdat[0] = 32'hB1B1_B1B1;
    check("mrst_b1_ack", {31'h0, ack[0]}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_async_ack", {31'h0, ack[0]}, 32'h0);
    check("mrst_async_dat", rdat[0], 32'h0);
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tmp = peek(0, 192);
    check("mrst_beat0_kept", tmp, 32'hB0B0_B0B0);
    check("mrst_beat1_absent", peek(0, 193), 32'h0);
    check("mrst_beat2_absent", peek(0, 194), 32'h0);
    check("mrst_idle", {30'h0, dbg[0]}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
